// File: rtl/ysyx_24120011_xbar_if.sv
// AXI4 port bundle shared by the crossbar's upstream side and both slave sides.
// Signals: ar*/aw*/w* request channels driven by the master, r*/b* response
// channels driven by the slave, plus the matching ready/valid pair of each.
// Modports: master (issues requests), slave (answers them).
interface ysyx_24120011_xbar_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        rlast;
    logic [3:0]  rid;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        wlast;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  bid;

    modport master (
        output araddr, arvalid, arid, arlen, arsize, arburst,
        input  arready,
        input  rdata, rresp, rvalid, rlast, rid,
        output rready,
        output awaddr, awvalid, awid, awlen, awsize, awburst,
        input  awready,
        output wdata, wstrb, wvalid, wlast,
        input  wready,
        input  bresp, bvalid, bid,
        output bready
    );

    modport slave (
        input  araddr, arvalid, arid, arlen, arsize, arburst,
        output arready,
        output rdata, rresp, rvalid, rlast, rid,
        input  rready,
        input  awaddr, awvalid, awid, awlen, awsize, awburst,
        output awready,
        input  wdata, wstrb, wvalid, wlast,
        output wready,
        output bresp, bvalid, bid,
        input  bready
    );
endinterface

// File: rtl/ysyx_24120011_xbar.sv
// Address-decoding AXI4 crossbar: routes the single granted upstream port to
// S0 (SoC main bus) or S1 (CLINT), one transaction at a time, with the route
// locked from the address handshake until the final R beat or the B response.
// Ports: clk, rst (async, active-high); m = upstream port (slave modport);
//        s0, s1 = downstream slave ports (master modport).
// Option: define YSYX_24120011_XBAR_DECERR_EN to add an internal responder that
//         answers unmatched addresses with DECERR; otherwise misses go to S0.
module ysyx_24120011_xbar #(
    parameter logic [31:0] S0_BASE = 32'h0000_0000,
    parameter logic [31:0] S0_MASK = 32'h0000_0000,
    parameter logic [31:0] S1_BASE = 32'h0200_0000,
    parameter logic [31:0] S1_MASK = 32'hFFFF_0000
) (
    input  logic                        clk,
    input  logic                        rst,
    ysyx_24120011_xbar_if.slave         m,
    ysyx_24120011_xbar_if.master        s0,
    ysyx_24120011_xbar_if.master        s1
);

    typedef enum logic [2:0] {
        IDLE, RD_S0, RD_S1, RD_ERR, WR_S0, WR_S1, WR_ERR
    } state_t;

    state_t state, state_nx;

    // Target selection: S1 window has priority over S0.
    function automatic state_t decode(input logic [31:0] addr, input logic is_rd);
        if ((addr & S1_MASK) == S1_BASE) return is_rd ? RD_S1 : WR_S1;
`ifdef YSYX_24120011_XBAR_DECERR_EN
        if ((addr & S0_MASK) == S0_BASE) return is_rd ? RD_S0 : WR_S0;
        return is_rd ? RD_ERR : WR_ERR;
`else
        return is_rd ? RD_S0 : WR_S0;
`endif
    endfunction

`ifndef YSYX_24120011_XBAR_DECERR_EN
    // S0 window is irrelevant when every miss falls through to S0.
    logic unused_s0_win;
    assign unused_s0_win = ^(S0_BASE | S0_MASK);
`endif

    // Request payloads go to both slaves; only the valids are steered.
    assign s0.araddr  = m.araddr;   assign s1.araddr  = m.araddr;
    assign s0.arid    = m.arid;     assign s1.arid    = m.arid;
    assign s0.arlen   = m.arlen;    assign s1.arlen   = m.arlen;
    assign s0.arsize  = m.arsize;   assign s1.arsize  = m.arsize;
    assign s0.arburst = m.arburst;  assign s1.arburst = m.arburst;
    assign s0.awaddr  = m.awaddr;   assign s1.awaddr  = m.awaddr;
    assign s0.awid    = m.awid;     assign s1.awid    = m.awid;
    assign s0.awlen   = m.awlen;    assign s1.awlen   = m.awlen;
    assign s0.awsize  = m.awsize;   assign s1.awsize  = m.awsize;
    assign s0.awburst = m.awburst;  assign s1.awburst = m.awburst;
    assign s0.wdata   = m.wdata;    assign s1.wdata   = m.wdata;
    assign s0.wstrb   = m.wstrb;    assign s1.wstrb   = m.wstrb;
    assign s0.wlast   = m.wlast;    assign s1.wlast   = m.wlast;

`ifdef YSYX_24120011_XBAR_DECERR_EN
    // DECERR responder context: address accepted, write data drained, id/len/beat.
    logic       err_addr_done;
    logic       err_w_done;
    logic [3:0] err_id;
    logic [7:0] err_len;
    logic [7:0] err_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_addr_done <= 1'b0;
            err_w_done    <= 1'b0;
            err_id        <= 4'd0;
            err_len       <= 8'd0;
            err_cnt       <= 8'd0;
        end else begin
            case (state)
                RD_ERR: begin
                    if (!err_addr_done) begin
                        if (m.arvalid) begin
                            err_addr_done <= 1'b1;
                            err_id        <= m.arid;
                            err_len       <= m.arlen;
                        end
                    end else if (m.rready && (err_cnt != err_len)) begin
                        // Final beat leaves the counter alone so arlen=255 never wraps.
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
                WR_ERR: begin
                    if (!err_addr_done) begin
                        if (m.awvalid) begin
                            err_addr_done <= 1'b1;
                            err_id        <= m.awid;
                        end
                    end else if (!err_w_done && m.wvalid && m.wlast) begin
                        err_w_done <= 1'b1;
                    end
                end
                default: begin
                    err_addr_done <= 1'b0;
                    err_w_done    <= 1'b0;
                    err_cnt       <= 8'd0;
                end
            endcase
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state and channel steering.
    always_comb begin
        state_nx   = state;
        s0.arvalid = 1'b0;  s1.arvalid = 1'b0;
        s0.rready  = 1'b0;  s1.rready  = 1'b0;
        s0.awvalid = 1'b0;  s1.awvalid = 1'b0;
        s0.wvalid  = 1'b0;  s1.wvalid  = 1'b0;
        s0.bready  = 1'b0;  s1.bready  = 1'b0;
        m.arready  = 1'b0;
        m.rdata    = 32'd0;
        m.rresp    = 2'b00;
        m.rvalid   = 1'b0;
        m.rlast    = 1'b0;
        m.rid      = 4'd0;
        m.awready  = 1'b0;
        m.wready   = 1'b0;
        m.bresp    = 2'b00;
        m.bvalid   = 1'b0;
        m.bid      = 4'd0;

        case (state)
            IDLE: begin
                if (m.arvalid)      state_nx = decode(m.araddr, 1'b1);
                else if (m.awvalid) state_nx = decode(m.awaddr, 1'b0);
            end
            RD_S0: begin
                s0.arvalid = m.arvalid;
                m.arready  = s0.arready;
                s0.rready  = m.rready;
                m.rdata    = s0.rdata;
                m.rresp    = s0.rresp;
                m.rvalid   = s0.rvalid;
                m.rlast    = s0.rlast;
                m.rid      = s0.rid;
                if (s0.rvalid && m.rready && s0.rlast) state_nx = IDLE;
            end
            RD_S1: begin
                s1.arvalid = m.arvalid;
                m.arready  = s1.arready;
                s1.rready  = m.rready;
                m.rdata    = s1.rdata;
                m.rresp    = s1.rresp;
                m.rvalid   = s1.rvalid;
                m.rlast    = s1.rlast;
                m.rid      = s1.rid;
                if (s1.rvalid && m.rready && s1.rlast) state_nx = IDLE;
            end
            WR_S0: begin
                s0.awvalid = m.awvalid;
                m.awready  = s0.awready;
                s0.wvalid  = m.wvalid;
                m.wready   = s0.wready;
                s0.bready  = m.bready;
                m.bresp    = s0.bresp;
                m.bvalid   = s0.bvalid;
                m.bid      = s0.bid;
                if (s0.bvalid && m.bready) state_nx = IDLE;
            end
            WR_S1: begin
                s1.awvalid = m.awvalid;
                m.awready  = s1.awready;
                s1.wvalid  = m.wvalid;
                m.wready   = s1.wready;
                s1.bready  = m.bready;
                m.bresp    = s1.bresp;
                m.bvalid   = s1.bvalid;
                m.bid      = s1.bid;
                if (s1.bvalid && m.bready) state_nx = IDLE;
            end
`ifdef YSYX_24120011_XBAR_DECERR_EN
            RD_ERR: begin
                m.arready = !err_addr_done;
                m.rvalid  = err_addr_done;
                m.rresp   = err_addr_done ? 2'b11 : 2'b00;
                m.rid     = err_addr_done ? err_id : 4'd0;
                m.rlast   = err_addr_done && (err_cnt == err_len);
                if (m.rvalid && m.rready && m.rlast) state_nx = IDLE;
            end
            WR_ERR: begin
                m.awready = !err_addr_done;
                m.wready  = err_addr_done && !err_w_done;
                m.bvalid  = err_w_done;
                m.bresp   = err_w_done ? 2'b11 : 2'b00;
                m.bid     = err_w_done ? err_id : 4'd0;
                if (err_w_done && m.bready) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24120011_xbar.sv
// Directed bench for ysyx_24120011_xbar: drives the upstream master and both
// slaves from one initial block and checks routed signals with hand-computed values.
module tb_ysyx_24120011_xbar;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    ysyx_24120011_xbar_if m_bus();
    ysyx_24120011_xbar_if s0_bus();
    ysyx_24120011_xbar_if s1_bus();

    ysyx_24120011_xbar #(
        .S0_BASE(32'h8000_0000),
        .S0_MASK(32'hF000_0000),
        .S1_BASE(32'h0200_0000),
        .S1_MASK(32'hFFFF_0000)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m  (m_bus.slave),
        .s0 (s0_bus.master),
        .s1 (s1_bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m_bus.araddr = '0; m_bus.arvalid = 0; m_bus.arid = '0; m_bus.arlen = '0;
        m_bus.arsize = 3'd2; m_bus.arburst = 2'b01; m_bus.rready = 0;
        m_bus.awaddr = '0; m_bus.awvalid = 0; m_bus.awid = '0; m_bus.awlen = '0;
        m_bus.awsize = 3'd2; m_bus.awburst = 2'b01;
        m_bus.wdata = '0; m_bus.wstrb = '0; m_bus.wvalid = 0; m_bus.wlast = 0;
        m_bus.bready = 0;
        s0_bus.arready = 0; s0_bus.rdata = '0; s0_bus.rresp = '0; s0_bus.rvalid = 0;
        s0_bus.rlast = 0; s0_bus.rid = '0; s0_bus.awready = 0; s0_bus.wready = 0;
        s0_bus.bresp = '0; s0_bus.bvalid = 0; s0_bus.bid = '0;
        s1_bus.arready = 0; s1_bus.rdata = '0; s1_bus.rresp = '0; s1_bus.rvalid = 0;
        s1_bus.rlast = 0; s1_bus.rid = '0; s1_bus.awready = 0; s1_bus.wready = 0;
        s1_bus.bresp = '0; s1_bus.bvalid = 0; s1_bus.bid = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        idle_all();

        // Reset: everything quiet even with a request pending.
        m_bus.arvalid = 1; m_bus.araddr = 32'h8000_0000;
        s0_bus.rvalid = 1; s0_bus.rdata = 32'hFFFF_FFFF;
        #2;
        chk("rst_arready", m_bus.arready, 0);
        chk("rst_rvalid",  m_bus.rvalid, 0);
        chk("rst_rdata",   m_bus.rdata, 0);
        chk("rst_bvalid",  m_bus.bvalid, 0);
        chk("rst_s0_arv",  s0_bus.arvalid, 0);
        cyc(); cyc();
        idle_all();
        rst = 1'b0;
        cyc();

        // Read to S0: arlen=3, arid=2.
        m_bus.araddr = 32'h8000_0000; m_bus.arlen = 8'd3; m_bus.arid = 4'd2;
        m_bus.arvalid = 1; s0_bus.arready = 1;
        #1;
        chk("rd0_lat_arv", s0_bus.arvalid, 0);
        chk("rd0_lat_ard", m_bus.arready, 0);
        cyc();
        chk("rd0_s0_arv",  s0_bus.arvalid, 1);
        chk("rd0_s1_arv",  s1_bus.arvalid, 0);
        chk("rd0_arready", m_bus.arready, 1);
        chk("rd0_arlen",   s0_bus.arlen, 3);
        cyc();
        m_bus.arvalid = 0; s0_bus.arready = 0; m_bus.rready = 1;
        for (int i = 0; i < 4; i++) begin
            s0_bus.rvalid = 1; s0_bus.rdata = 32'h100 + i; s0_bus.rid = 4'd2;
            s0_bus.rlast = (i == 3);
            #1;
            chk("rd0_rvalid", m_bus.rvalid, 1);
            chk("rd0_rdata",  m_bus.rdata, 32'h100 + i);
            chk("rd0_rid",    m_bus.rid, 2);
            chk("rd0_rlast",  m_bus.rlast, (i == 3) ? 1 : 0);
            cyc();
        end
        #1;
        chk("rd0_done", m_bus.rvalid, 0);
        idle_all();
        cyc();

        // Read to S1 (CLINT mtime), single beat.
        m_bus.araddr = 32'h0200_BFF8; m_bus.arlen = 8'd0; m_bus.arid = 4'd5;
        m_bus.arvalid = 1; s1_bus.arready = 1; s0_bus.arready = 1;
        cyc();
        chk("rd1_s1_arv", s1_bus.arvalid, 1);
        chk("rd1_s0_arv", s0_bus.arvalid, 0);
        cyc();
        m_bus.arvalid = 0; m_bus.rready = 1;
        s1_bus.rvalid = 1; s1_bus.rdata = 32'h1234_5678; s1_bus.rlast = 1; s1_bus.rid = 4'd5;
        s0_bus.rvalid = 1; s0_bus.rdata = 32'hBAD0_BAD0; s0_bus.rlast = 1;
        #1;
        chk("rd1_rdata",  m_bus.rdata, 32'h1234_5678);
        chk("rd1_rlast",  m_bus.rlast, 1);
        chk("rd1_rid",    m_bus.rid, 5);
        chk("rd1_s0_rrd", s0_bus.rready, 0);
        chk("rd1_s1_rrd", s1_bus.rready, 1);
        cyc();
        idle_all();
        cyc();

        // Collision: read to S0 and write to S1 together; read goes first.
        m_bus.araddr = 32'h8000_0004; m_bus.arlen = 8'd0; m_bus.arid = 4'd1; m_bus.arvalid = 1;
        m_bus.awaddr = 32'h0200_0000; m_bus.awlen = 8'd0; m_bus.awid = 4'd3; m_bus.awvalid = 1;
        s0_bus.arready = 1; s1_bus.awready = 1; s1_bus.wready = 1;
        cyc();
        chk("col_s0_arv",  s0_bus.arvalid, 1);
        chk("col_s1_awv",  s1_bus.awvalid, 0);
        chk("col_awready", m_bus.awready, 0);
        cyc();
        m_bus.arvalid = 0; m_bus.rready = 1;
        s0_bus.rvalid = 1; s0_bus.rlast = 1; s0_bus.rdata = 32'hAA;
        #1;
        chk("col_rvalid", m_bus.rvalid, 1);
        cyc();
        s0_bus.rvalid = 0; s0_bus.rlast = 0;
        #1;
        chk("col_idle_awv", s1_bus.awvalid, 0);
        cyc();
        chk("col_s1_awv2", s1_bus.awvalid, 1);
        chk("col_awready2", m_bus.awready, 1);
        cyc();
        m_bus.awvalid = 0;
        m_bus.wvalid = 1; m_bus.wdata = 32'hDEAD_BEEF; m_bus.wstrb = 4'hF; m_bus.wlast = 1;
        #1;
        chk("col_s1_wv",   s1_bus.wvalid, 1);
        chk("col_s1_wstrb", s1_bus.wstrb, 4'hF);
        chk("col_s1_wdata", s1_bus.wdata, 32'hDEAD_BEEF);
        chk("col_wready",  m_bus.wready, 1);
        chk("col_s0_wv",   s0_bus.wvalid, 0);
        cyc();
        m_bus.wvalid = 0; m_bus.wlast = 0; m_bus.bready = 1;
        s1_bus.bvalid = 1; s1_bus.bresp = 2'b00; s1_bus.bid = 4'd3;
        #1;
        chk("col_bvalid", m_bus.bvalid, 1);
        chk("col_bresp",  m_bus.bresp, 0);
        chk("col_bid",    m_bus.bid, 3);
        cyc();
        chk("col_bdone",  m_bus.bvalid, 0);
        idle_all();
        cyc();

        // Back-pressure on R: two beats, rready toggling.
        m_bus.araddr = 32'h8000_0010; m_bus.arlen = 8'd1; m_bus.arid = 4'd4;
        m_bus.arvalid = 1; s0_bus.arready = 1;
        cyc(); cyc();
        m_bus.arvalid = 0; s0_bus.arready = 0;
        s0_bus.rvalid = 1; s0_bus.rdata = 32'hD0; s0_bus.rid = 4'd4; m_bus.rready = 0;
        #1;
        chk("bp_rvalid0", m_bus.rvalid, 1);
        chk("bp_rdata0",  m_bus.rdata, 32'hD0);
        chk("bp_s0_rrd0", s0_bus.rready, 0);
        cyc();
        chk("bp_rdata0b", m_bus.rdata, 32'hD0);
        m_bus.rready = 1;
        #1;
        chk("bp_s0_rrd1", s0_bus.rready, 1);
        cyc();
        s0_bus.rdata = 32'hD1; s0_bus.rlast = 1; m_bus.rready = 0;
        cyc();
        chk("bp_hold_rv", m_bus.rvalid, 1);
        chk("bp_rdata1",  m_bus.rdata, 32'hD1);
        m_bus.rready = 1;
        cyc();
        chk("bp_done",    m_bus.rvalid, 0);
        idle_all();
        cyc();

`ifdef YSYX_24120011_XBAR_DECERR_EN
        // Unmapped read answered internally with DECERR.
        m_bus.araddr = 32'h1000_0000; m_bus.arlen = 8'd2; m_bus.arid = 4'd6; m_bus.arvalid = 1;
        s0_bus.arready = 1;
        cyc();
        chk("er_arready", m_bus.arready, 1);
        chk("er_s0_arv",  s0_bus.arvalid, 0);
        chk("er_rv_pre",  m_bus.rvalid, 0);
        cyc();
        m_bus.arvalid = 0; m_bus.rready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("er_rvalid", m_bus.rvalid, 1);
            chk("er_rdata",  m_bus.rdata, 0);
            chk("er_rresp",  m_bus.rresp, 2'b11);
            chk("er_rid",    m_bus.rid, 6);
            chk("er_rlast",  m_bus.rlast, (i == 2) ? 1 : 0);
            cyc();
        end
        chk("er_rdone", m_bus.rvalid, 0);
        idle_all();
        cyc();

        // Unmapped write: two beats sunk, then DECERR response.
        m_bus.awaddr = 32'h1000_0000; m_bus.awlen = 8'd1; m_bus.awid = 4'd9; m_bus.awvalid = 1;
        s0_bus.awready = 1;
        cyc();
        chk("ew_awready", m_bus.awready, 1);
        chk("ew_s0_awv",  s0_bus.awvalid, 0);
        chk("ew_wrd_pre", m_bus.wready, 0);
        cyc();
        m_bus.awvalid = 0; m_bus.wvalid = 1; m_bus.wlast = 0;
        #1;
        chk("ew_wready0", m_bus.wready, 1);
        chk("ew_bv_pre",  m_bus.bvalid, 0);
        cyc();
        m_bus.wlast = 1;
        #1;
        chk("ew_wready1", m_bus.wready, 1);
        cyc();
        m_bus.wvalid = 0; m_bus.wlast = 0;
        #1;
        chk("ew_bvalid", m_bus.bvalid, 1);
        chk("ew_bresp",  m_bus.bresp, 2'b11);
        chk("ew_bid",    m_bus.bid, 9);
        chk("ew_wrd_post", m_bus.wready, 0);
        cyc();
        chk("ew_bhold", m_bus.bvalid, 1);
        m_bus.bready = 1;
        cyc();
        chk("ew_bdone", m_bus.bvalid, 0);
        idle_all();
        cyc();
`else
        // Without the responder, unmapped addresses fall through to S0.
        m_bus.araddr = 32'h1000_0000; m_bus.arlen = 8'd0; m_bus.arid = 4'd6; m_bus.arvalid = 1;
        s0_bus.arready = 1;
        cyc();
        chk("nm_s0_arv", s0_bus.arvalid, 1);
        chk("nm_s1_arv", s1_bus.arvalid, 0);
        cyc();
        m_bus.arvalid = 0; m_bus.rready = 1;
        s0_bus.rvalid = 1; s0_bus.rlast = 1; s0_bus.rdata = 32'h77;
        #1;
        chk("nm_rdata", m_bus.rdata, 32'h77);
        cyc();
        idle_all();
        cyc();
`endif

        // Reset during beat 2 of a 4-beat read, then a fresh read to S1.
        m_bus.araddr = 32'h8000_0020; m_bus.arlen = 8'd3; m_bus.arid = 4'd7;
        m_bus.arvalid = 1; s0_bus.arready = 1;
        cyc(); cyc();
        m_bus.arvalid = 0; s0_bus.arready = 0; m_bus.rready = 1;
        s0_bus.rvalid = 1; s0_bus.rdata = 32'hE0; s0_bus.rid = 4'd7;
        cyc();
        s0_bus.rdata = 32'hE1;
        rst = 1'b1;
        #1;
        chk("mr_rvalid", m_bus.rvalid, 0);
        chk("mr_rdata",  m_bus.rdata, 0);
        chk("mr_rid",    m_bus.rid, 0);
        chk("mr_s0_rrd", s0_bus.rready, 0);
        cyc();
        rst = 1'b0;
        idle_all();
        m_bus.araddr = 32'h0200_0004; m_bus.arlen = 8'd0; m_bus.arid = 4'd1;
        m_bus.arvalid = 1; s1_bus.arready = 1;
        cyc();
        chk("mr_s1_arv", s1_bus.arvalid, 1);
        chk("mr_s0_arv", s0_bus.arvalid, 0);
        cyc();
        m_bus.arvalid = 0; m_bus.rready = 1;
        s1_bus.rvalid = 1; s1_bus.rlast = 1; s1_bus.rdata = 32'h55;
        #1;
        chk("mr_rdata2", m_bus.rdata, 32'h55);
        cyc();
        chk("mr_done", m_bus.rvalid, 0);
        idle_all();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
